// File: rtl/misr_sig_analyzer_pkg.sv
// Shared types and the signature update function for the MISR/SISR
// signature analyser. The same function drives the RTL register and the
// bench reference model.
package misr_pkg;

  // Widest signature the update function can handle.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CMP  = 2'd2
  } misr_state_e;

  // One compaction step of a w-bit internal-XOR signature register.
  // Bit 0 takes the feedback directly (POLY[0] is always 1); every other
  // bit shifts up and picks up the feedback where the polynomial has a tap.
  // Bits at and above w are returned as zero.
  function automatic logic [MAX_W-1:0] misr_next(
    input logic [MAX_W-1:0] sig,
    input logic [MAX_W-1:0] d,
    input logic [MAX_W-1:0] poly,
    input int               w
  );
    logic [MAX_W-1:0] nxt;
    logic             fb;
    nxt    = '0;
    fb     = sig[w-1];
    nxt[0] = d[0] ^ fb;
    for (int i = 1; i < MAX_W; i++) begin
      if (i < w) begin
        nxt[i] = d[i] ^ sig[i-1] ^ (poly[i] & fb);
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/misr_sig_analyzer_if.sv
// Session control, response stream and result bus between the BIST
// controller / CUT and the signature analyser.
interface misr_sig_analyzer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
);
  logic             start;
  logic             mode_serial;
  logic [WIDTH-1:0] seed;
  logic [CNT_W-1:0] num_vec;
  logic [WIDTH-1:0] golden;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             busy;
  logic [WIDTH-1:0] sig;
  logic             done;
  logic             pass;
  logic             fail;

  modport master (
    output start, mode_serial, seed, num_vec, golden, in_valid, in_data,
    input  in_ready, busy, sig, done, pass, fail
  );

  modport slave (
    input  start, mode_serial, seed, num_vec, golden, in_valid, in_data,
    output in_ready, busy, sig, done, pass, fail
  );
endinterface

// File: rtl/misr_sig_analyzer_core.sv
// Signature register: loads a seed or compacts one data word per shift.
module misr_core
  import misr_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] POLY  = 4'b1001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] sig_o
);

  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;
  logic [MAX_W-1:0] nxt_full;

  // Next signature: load wins over shift, otherwise hold.
  always_comb begin
    nxt_full = misr_next(MAX_W'(sig_q), MAX_W'(d_i), MAX_W'(POLY), WIDTH);
    sig_d    = sig_q;
    if (load_i) begin
      sig_d = seed_i;
    end else if (shift_i) begin
      sig_d = nxt_full[WIDTH-1:0];
    end
  end

  // Signature register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/misr_sig_analyzer.sv
// Signature analyser top: session FSM, vector counter and golden compare
// around the misr_core signature register.
module misr_sig_analyzer
  import misr_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] POLY  = 4'b1001,
  parameter int               CNT_W = 16
) (
  input logic                clk,
  input logic                rst,
  misr_sig_analyzer_if.slave bus
);

  misr_state_e      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] num_vec_q, num_vec_d;
  logic [WIDTH-1:0] golden_q, golden_d;
  logic             mode_q, mode_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             done_q, done_d;

  logic             load;
  logic             shift;
  logic [WIDTH-1:0] core_d;
  logic [WIDTH-1:0] sig;
  logic             match;

  // Serial mode feeds only bit 0 into the register.
  assign core_d = mode_q ? {{(WIDTH-1){1'b0}}, bus.in_data[0]} : bus.in_data;
  assign match  = (sig == golden_q);

  misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .seed_i  (bus.seed),
    .shift_i (shift),
    .d_i     (core_d),
    .sig_o   (sig)
  );

  // Session FSM: next state, session latches, counter and result flags.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    num_vec_d = num_vec_q;
    golden_d  = golden_q;
    mode_d    = mode_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    done_d    = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          mode_d    = bus.mode_serial;
          num_vec_d = bus.num_vec;
          golden_d  = bus.golden;
          count_d   = '0;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
          state_d   = (bus.num_vec == '0) ? CMP : RUN;
        end
      end
      RUN: begin
        if (bus.in_valid) begin
          shift   = 1'b1;
          count_d = count_q + CNT_W'(1);
          if (count_q == num_vec_q - CNT_W'(1)) begin
            state_d = CMP;
          end
        end
      end
      CMP: begin
        pass_d  = match;
        fail_d  = ~match;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and session registers; reset returns every output to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      num_vec_q <= '0;
      golden_q  <= '0;
      mode_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      num_vec_q <= num_vec_d;
      golden_q  <= golden_d;
      mode_q    <= mode_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      done_q    <= done_d;
    end
  end

  assign bus.in_ready = (state_q == RUN);
  assign bus.busy     = (state_q != IDLE);
  assign bus.sig      = sig;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.fail     = fail_q;

endmodule

// File: tb/tb_misr_sig_analyzer.sv
// Directed bench for misr_sig_analyzer (W=4, POLY=x^4+x^3+1).
module tb_misr_sig_analyzer;
  import misr_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] exp_sig;
  logic       serial_m;

  always #5 clk = ~clk;

  misr_sig_analyzer_if #(.WIDTH(4), .CNT_W(16)) bus ();

  misr_sig_analyzer #(
    .WIDTH (4),
    .POLY  (4'b1001),
    .CNT_W (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk_val({tag, "_sig"},   32'(bus.sig), 32'h0);
    chk_val({tag, "_busy"},  32'(bus.busy), 32'h0);
    chk_val({tag, "_rdy"},   32'(bus.in_ready), 32'h0);
    chk_val({tag, "_done"},  32'(bus.done), 32'h0);
    chk_val({tag, "_pass"},  32'(bus.pass), 32'h0);
    chk_val({tag, "_fail"},  32'(bus.fail), 32'h0);
  endtask

  // Pulse start for one cycle; optionally present a vector in the same cycle.
  task automatic start_sess(input logic m, input logic [3:0] sd, input logic [15:0] nv,
                            input logic [3:0] gd, input logic iv);
    bus.start       = 1'b1;
    bus.mode_serial = m;
    bus.seed        = sd;
    bus.num_vec     = nv;
    bus.golden      = gd;
    bus.in_valid    = iv;
    bus.in_data     = 4'hF;
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    exp_sig      = sd;
    serial_m     = m;
    chk_val("start_sig",  32'(bus.sig), 32'(sd));
    chk_val("start_busy", 32'(bus.busy), 32'h1);
    chk_val("start_rdy",  32'(bus.in_ready), 32'(nv != 16'd0));
    chk_val("start_pass", 32'(bus.pass), 32'h0);
    chk_val("start_fail", 32'(bus.fail), 32'h0);
  endtask

  // Idle for 'gaps' cycles (sig must hold), then present one vector.
  task automatic send_vec(input logic [3:0] data, input int gaps, input logic [3:0] hand);
    logic [MAX_W-1:0] tmp;
    logic [3:0]       d;
    for (int g = 0; g < gaps; g++) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 4'(g + 3);
      tick();
      chk_val("gap_sig", 32'(bus.sig), 32'(exp_sig));
    end
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    tick();
    bus.in_valid = 1'b0;
    d       = serial_m ? {3'b000, data[0]} : data;
    tmp     = misr_next(MAX_W'(exp_sig), MAX_W'(d), MAX_W'(4'b1001), 4);
    exp_sig = tmp[3:0];
    chk_val("model_sig", 32'(bus.sig), 32'(exp_sig));
    chk_val("hand_sig",  32'(bus.sig), 32'(hand));
  endtask

  // Called right after the last vector: one CMP cycle, then the done cycle.
  task automatic chk_result(input logic exp_pass, input logic [3:0] final_sig);
    chk_val("cmp_done", 32'(bus.done), 32'h0);
    chk_val("cmp_busy", 32'(bus.busy), 32'h1);
    chk_val("cmp_rdy",  32'(bus.in_ready), 32'h0);
    tick();
    chk_val("res_done", 32'(bus.done), 32'h1);
    chk_val("res_pass", 32'(bus.pass), 32'(exp_pass));
    chk_val("res_fail", 32'(bus.fail), 32'(!exp_pass));
    chk_val("res_busy", 32'(bus.busy), 32'h0);
    chk_val("res_sig",  32'(bus.sig), 32'(final_sig));
  endtask

  task automatic chk_after_done(input logic exp_pass);
    tick();
    chk_val("post_done", 32'(bus.done), 32'h0);
    chk_val("post_pass", 32'(bus.pass), 32'(exp_pass));
    chk_val("post_fail", 32'(bus.fail), 32'(!exp_pass));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rnd;
    bus.start = 0; bus.mode_serial = 0; bus.seed = 0; bus.num_vec = 0;
    bus.golden = 0; bus.in_valid = 0; bus.in_data = 0;
    rst = 1'b1;
    tick();
    tick();
    chk_idle_outs("reset");
    rst = 1'b0;
    tick();

    // Parallel: 0101,0000,0000 -> 0101,1010,1101; golden 1101 passes.
    start_sess(1'b0, 4'h0, 16'd3, 4'hD, 1'b0);
    send_vec(4'b0101, 0, 4'b0101);
    send_vec(4'b0000, 0, 4'b1010);
    send_vec(4'b0000, 0, 4'b1101);
    chk_result(1'b1, 4'b1101);
    chk_after_done(1'b1);

    // Serial: bit0 = 1,0,0,0,0 with random upper bits; golden 1000 fails.
    start_sess(1'b1, 4'h0, 16'd5, 4'h8, 1'b0);
    rnd = 4'($urandom) & 4'hE; send_vec(rnd | 4'h1, 0, 4'b0001);
    rnd = 4'($urandom) & 4'hE; send_vec(rnd, 0, 4'b0010);
    rnd = 4'($urandom) & 4'hE; send_vec(rnd, 0, 4'b0100);
    rnd = 4'($urandom) & 4'hE; send_vec(rnd, 0, 4'b1000);
    rnd = 4'($urandom) & 4'hE; send_vec(rnd, 0, 4'b1001);
    chk_result(1'b0, 4'b1001);
    chk_after_done(1'b0);

    // Parallel with idle gaps between vectors: same signature and result.
    start_sess(1'b0, 4'h0, 16'd3, 4'hD, 1'b0);
    send_vec(4'b0101, int'($urandom_range(1, 3)), 4'b0101);
    send_vec(4'b0000, int'($urandom_range(1, 3)), 4'b1010);
    send_vec(4'b0000, int'($urandom_range(0, 3)), 4'b1101);
    chk_result(1'b1, 4'b1101);
    chk_after_done(1'b1);

    // num_vec 0 with in_valid during start; start/in_valid in CMP ignored.
    start_sess(1'b0, 4'hB, 16'd0, 4'hB, 1'b1);
    bus.start = 1'b1; bus.seed = 4'h0; bus.in_valid = 1'b1; bus.in_data = 4'h5;
    chk_result(1'b1, 4'hB);
    bus.start = 1'b0;
    tick();
    chk_val("idle_valid_sig",  32'(bus.sig), 32'hB);
    chk_val("idle_valid_busy", 32'(bus.busy), 32'h0);
    chk_val("idle_valid_pass", 32'(bus.pass), 32'h1);
    bus.in_valid = 1'b0;

    // start asserted in RUN is ignored; session length is unaffected.
    start_sess(1'b0, 4'h0, 16'd2, 4'hA, 1'b0);
    send_vec(4'b0101, 0, 4'b0101);
    bus.start = 1'b1; bus.seed = 4'hF; bus.num_vec = 16'd7;
    send_vec(4'b0000, 0, 4'b1010);
    bus.start = 1'b0;
    chk_result(1'b1, 4'b1010);
    chk_after_done(1'b1);

    // Reset mid-session after two vectors aborts with no done.
    start_sess(1'b0, 4'h0, 16'd3, 4'hD, 1'b0);
    send_vec(4'b0101, 0, 4'b0101);
    send_vec(4'b0000, 0, 4'b1010);
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 4'h0;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk_idle_outs("abort");
    tick();
    chk_idle_outs("abort2");

    // Fresh session after reset, then back-to-back start in the done cycle.
    start_sess(1'b0, 4'h0, 16'd3, 4'hD, 1'b0);
    send_vec(4'b0101, 0, 4'b0101);
    send_vec(4'b0000, 0, 4'b1010);
    send_vec(4'b0000, 0, 4'b1101);
    chk_result(1'b1, 4'b1101);
    start_sess(1'b1, 4'h0, 16'd5, 4'h8, 1'b0);
    chk_val("b2b_done", 32'(bus.done), 32'h0);
    send_vec(4'b0111, 0, 4'b0001);
    send_vec(4'b1110, 0, 4'b0010);
    send_vec(4'b0000, 0, 4'b0100);
    send_vec(4'b1010, 0, 4'b1000);
    send_vec(4'b0110, 0, 4'b1001);
    chk_result(1'b0, 4'b1001);
    chk_after_done(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/misr_sig_analyzer.md
# misr_sig_analyzer

Parametrised signature analyser for the BIST path. It compacts a run-time-programmed number of response vectors into a WIDTH-bit signature, using either a parallel multiple-input register (MISR) or a serial single-input register (SISR) on bit 0. At the end of the session it compares the signature against a golden value and reports pass/fail with a one-cycle done pulse. It sits between the CUT response bus and the BIST controller, which owns start, seed and golden values.

## Interface
- WIDTH, 4: signature and data width, ≥ 2.
- POLY, 4'b1001: feedback polynomial. POLY[i] is the coefficient of x^i for i = 0..WIDTH-1; x^WIDTH is implicit. POLY[0] must be 1. The default is x^4+x^3+1.
- CNT_W, 16: width of the vector counter.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  starts a session; sampled in IDLE only.
- mode_serial  in  1  1 = SISR (in_data[0] only), 0 = MISR; latched on start.
- seed  in  WIDTH  initial signature; latched on start.
- num_vec  in  CNT_W  number of vectors to compact; latched on start.
- golden  in  WIDTH  expected signature; latched on start.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  WIDTH  response vector.
- in_ready  out  1  high in RUN; a vector is accepted when in_valid && in_ready.
- busy  out  1  high in RUN or CMP.
- sig  out  WIDTH  current signature.
- done  out  1  one-cycle pulse when the result is valid.
- pass  out  1  sig == golden for the last session; held until the next start.
- fail  out  1  complement of pass once a session has completed; held until the next start.

## Operation
- States:
  - IDLE: start moves to RUN, or to CMP if num_vec == 0.
  - RUN: waits for and accepts vectors (see below).
  - CMP: compares for one cycle, then returns to IDLE.
- On start in IDLE:
  - sig ← seed.
  - mode_serial, num_vec and golden are latched.
  - count ← 0; pass ← 0; fail ← 0.
- Each accepted vector in RUN:
  - d = mode_serial ? {0…0, in_data[0]} : in_data.
  - next[0] = d[0] ^ sig[W-1].
  - next[i] = d[i] ^ sig[i-1] ^ (POLY[i] & sig[W-1]) for i ≥ 1.
  - count ← count+1.
  - On the accepted vector where count == num_vec-1, move to CMP.
- In CMP:
  - pass ← (sig == golden_q); fail ← ~(sig == golden_q).
  - done ← 1 for that edge's following cycle.
  - Move to IDLE.
- Ignored inputs:
  - start outside IDLE.
  - in_valid outside RUN, including in the same cycle as start.
  - in_data bits [W-1:1] in serial mode.
- The only way to abort a session is rst.

## Timing
- Reset values: state IDLE, sig 0, count 0, in_ready 0, busy 0, done 0, pass 0, fail 0.
- Start at edge E0: sig = seed and in_ready = 1 from E0; the first vector can be accepted at E1.
- One vector per cycle at full rate. in_valid may drop at any time; sig holds while no vector is accepted.
- Final vector at edge Ef: sig is final after Ef; pass/fail/done are registered at Ef+1. done is high for exactly one cycle.
- num_vec == 0: start at E0 → CMP; done at E0+1 with sig = seed compared against golden.
- Back-to-back sessions: start is accepted in the cycle done is high (state is IDLE). The new start clears pass/fail at that edge.
- rst asserted in any state overrides everything at the next edge and returns all outputs to their reset values. No done is produced for the aborted session.
- count wraps never: num_vec ≤ 2^CNT_W-1 by construction.

## Structure
- Package misr_pkg:
  - the state enum (IDLE, RUN, CMP);
  - function misr_next(sig, d, poly) implementing the update equations, shared with the bench model.
- Sub-module misr_core:
  - holds the WIDTH-bit register, with inputs load/seed, shift/d, and parameter POLY;
  - the top-level FSM, counter and compare stay in misr_sig_analyzer.

## Test plan
- Parallel, W=4, POLY=1001, seed 0, num_vec 3, vectors 0101, 0000, 0000 → sig 0101, 1010, 1101. With golden 1101: done one cycle after the last vector, pass=1, fail=0.
- Serial, seed 0, num_vec 5, in_data[0] = 1,0,0,0,0 with upper bits randomised → sig 0001, 0010, 0100, 1000, 1001. With golden 1000: pass=0, fail=1.
- Gaps in in_valid (random 0–3 idle cycles between the three vectors of the first test) → same final sig 1101, same pass result; sig is stable during gaps.
- num_vec 0, seed 1011, golden 1011 → done at start+1, pass=1. start asserted while busy and in_valid in IDLE → no effect on sig or count.
- rst asserted mid-session after two vectors → the next cycle shows sig 0, busy 0, in_ready 0, pass 0, fail 0 and no done. A new session after rst yields correct results.
- Back-to-back: start asserted in the done cycle → pass/fail cleared at that edge and the second session completes correctly. The bench compares every update against misr_next.
